// File: rtl/sync_pkg.sv
// Shared definitions for the sync sequencer.
//   state_t         : FSM state encoding (IDLE, ARM, FG_DLY, TRIG_DLY, DET_DLY)
//   FG_DELAY,
//   TRIGGER_DELAY,
//   DETECTOR_DELAY  : default delay settings in clock cycles
package sync_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StArm     = 3'd1;
  localparam state_t StFgDly   = 3'd2;
  localparam state_t StTrigDly = 3'd3;
  localparam state_t StDetDly  = 3'd4;

  localparam int unsigned FG_DELAY       = 100_000;
  localparam int unsigned TRIGGER_DELAY  = 350_000;
  localparam int unsigned DETECTOR_DELAY = 5;

endpackage

// File: rtl/delay_counter.sv
// Cycle counter shared by every waiting state of the sequencer.
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   clear_i       : synchronous load of zero (has priority over enable_i)
//   enable_i      : increment by one
//   cmp_value_i   : value compared against the current count
//   count_o       : current count
//   equal_o       : count_o == cmp_value_i (combinational, pre-increment)
module delay_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] cmp_value_i,
  output logic [CNT_W-1:0] count_o,
  output logic             equal_o
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count_o = count_q;
  assign equal_o = (count_q == cmp_value_i);

endmodule

// File: rtl/sync_sequencer.sv
// Trigger/detector sequencer locked to a function-generator marker.
// After an accepted start it waits for a rising edge of fg_signal, then counts
// cfg_fg_delay, fires trigger, counts cfg_trigger_delay and cfg_detector_delay,
// fires detector, and repeats until cfg_shots detector pulses have been issued.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   start, abort        : sequence request / cancel
//   fg_signal           : function-generator marker (synchronous to clock)
//   cfg_*               : delays (cycles) and shot count, latched on start
//   trigger_signal      : one-cycle trigger pulse
//   detector_signal     : one-cycle detector pulse
//   busy                : sequence in progress
//   done                : one-cycle pulse on completion
//   timeout_err         : one-cycle pulse when no fg edge arrives in time
//   shot_count          : detector pulses issued in the current/last sequence
module sync_sequencer
  import sync_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SHOTS_W    = 16,
  parameter int unsigned FG_TIMEOUT = 10_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               fg_signal,
  input  logic [CNT_W-1:0]   cfg_fg_delay,
  input  logic [CNT_W-1:0]   cfg_trigger_delay,
  input  logic [CNT_W-1:0]   cfg_detector_delay,
  input  logic [SHOTS_W-1:0] cfg_shots,
  output logic               trigger_signal,
  output logic               detector_signal,
  output logic               busy,
  output logic               done,
  output logic               timeout_err,
  output logic [SHOTS_W-1:0] shot_count
);

  localparam bit TimeoutEn = (FG_TIMEOUT != 0);
  // Counter starts at 0 on ARM entry, so the N-th ARM cycle sees count N-1.
  localparam logic [CNT_W-1:0] TimeoutCmp = TimeoutEn ? CNT_W'(FG_TIMEOUT - 1) : '0;

  state_t             state_q, state_d;
  logic               fg_prev_q;
  logic [CNT_W-1:0]   fg_dly_q, trig_dly_q, det_dly_q;
  logic [SHOTS_W-1:0] shots_q;
  logic [SHOTS_W-1:0] shot_count_q, shot_count_d;
  logic [SHOTS_W-1:0] shot_next;
  logic               trigger_q, trigger_d;
  logic               detector_q, detector_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               busy_q;
  logic               load_cfg;
  logic               fg_edge;

  logic               cnt_clear, cnt_en, cnt_eq;
  logic [CNT_W-1:0]   cnt_cmp;
  logic [CNT_W-1:0]   cnt_value;

  delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay_counter (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (cnt_clear),
    .enable_i    (cnt_en),
    .cmp_value_i (cnt_cmp),
    .count_o     (cnt_value),
    .equal_o     (cnt_eq)
  );

  assign fg_edge   = fg_signal & ~fg_prev_q;
  assign shot_next = shot_count_q + SHOTS_W'(1);

  always_comb begin
    state_d      = state_q;
    shot_count_d = shot_count_q;
    trigger_d    = 1'b0;
    detector_d   = 1'b0;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    load_cfg     = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    cnt_cmp      = '0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          load_cfg     = 1'b1;
          shot_count_d = '0;
          cnt_clear    = 1'b1;
          if (cfg_shots == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = StArm;
          end
        end
      end
      StArm: begin
        cnt_cmp = TimeoutCmp;
        if (fg_edge) begin
          state_d   = StFgDly;
          cnt_clear = 1'b1;
        end else if (TimeoutEn) begin
          if (cnt_eq) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
            cnt_clear = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StFgDly: begin
        cnt_cmp = fg_dly_q;
        if (cnt_eq) begin
          trigger_d = 1'b1;
          cnt_clear = 1'b1;
          state_d   = StTrigDly;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StTrigDly: begin
        cnt_cmp = trig_dly_q;
        if (cnt_eq) begin
          cnt_clear = 1'b1;
          state_d   = StDetDly;
        end else begin
          cnt_en = 1'b1;
        end
      end
      StDetDly: begin
        cnt_cmp = det_dly_q;
        if (cnt_eq) begin
          detector_d   = 1'b1;
          shot_count_d = shot_next;
          cnt_clear    = 1'b1;
          if (shot_next == shots_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StArm;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides whatever the active state decided this edge.
    if (abort && (state_q != StIdle)) begin
      state_d      = StIdle;
      shot_count_d = shot_count_q;
      trigger_d    = 1'b0;
      detector_d   = 1'b0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      cnt_clear    = 1'b0;
      cnt_en       = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      fg_prev_q    <= 1'b0;
      fg_dly_q     <= '0;
      trig_dly_q   <= '0;
      det_dly_q    <= '0;
      shots_q      <= '0;
      shot_count_q <= '0;
      trigger_q    <= 1'b0;
      detector_q   <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fg_prev_q    <= fg_signal;
      shot_count_q <= shot_count_d;
      trigger_q    <= trigger_d;
      detector_q   <= detector_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      busy_q       <= (state_d != StIdle);
      if (load_cfg) begin
        fg_dly_q   <= cfg_fg_delay;
        trig_dly_q <= cfg_trigger_delay;
        det_dly_q  <= cfg_detector_delay;
        shots_q    <= cfg_shots;
      end
    end
  end

  assign trigger_signal  = trigger_q;
  assign detector_signal = detector_q;
  assign done            = done_q;
  assign timeout_err     = timeout_q;
  assign busy            = busy_q;
  assign shot_count      = shot_count_q;

endmodule
